nand_gates_checker: RTL and testbench
=====================================

NAND_GATES_CHECKER -- requirements
Module: nand_gates_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles between driving a new input pair and sampling the gate outputs; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run a full self-test; honoured only in IDLE.
REQ-005 y_in  input  8  gate outputs under test, indexed 0..7: 0=NOT a, 1=NOT b, 2=NAND, 3=AND, 4=OR, 5=NOR, 6=XOR, 7=XNOR.
REQ-006 a_out  output  1  stimulus bit a to the gate block.
REQ-007 b_out  output  1  stimulus bit b to the gate block.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-009 done  output  1  one-cycle pulse at end of run.
REQ-010 pass  output  1  high when the last completed run had zero mismatches; held until the next accepted start.
REQ-011 fail_vec  output  4  bit k set when vector k (k = {a,b}) mismatched in the last run.
REQ-012 err_count  output  3  number of failing vectors in the last run, 0..4.
REQ-013 first_diff  output  8  XOR of expected and sampled y_in for the first failing vector; zero if none.

Function
REQ-014 FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE: start=1 -> DRIVE; clears fail_vec, err_count, first_diff and pass; vector index = 0.
REQ-016 DRIVE: a_out/b_out = index[1]/index[0]; loads settle counter with SETTLE_CYCLES-1; -> SETTLE.
REQ-017 SETTLE: decrements counter each cycle; at zero -> SAMPLE; stimulus held stable.
REQ-018 SAMPLE: compares y_in with expected vector for index; on mismatch sets fail_vec[index] and increments err_count; loads first_diff only if err_count was 0.
REQ-019 SAMPLE: index < 3 -> increment index, -> DRIVE; index = 3 -> DONE.
REQ-020 DONE: done=1 for exactly this cycle; pass = (err_count == 0) including the final sample's result; busy=0; -> IDLE.
REQ-021 Expected values: bit0=~a, bit1=~b, bit2=~(a&b), bit3=a&b, bit4=a|b, bit5=~(a|b), bit6=a^b, bit7=~(a^b).
REQ-022 Start-to-done latency is exactly 1 + 4*(SETTLE_CYCLES+2) cycles (start cycle in IDLE, then per vector DRIVE + SETTLE_CYCLES + SAMPLE, then DONE).
REQ-023 start asserted while busy or in DONE is ignored, not queued.
REQ-024 Outside a run a_out and b_out are 0.
REQ-025 y_in is sampled only in SAMPLE; changes on y_in in other states have no effect.

Reset
REQ-026 rst=1 forces IDLE, index=0, counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, first_diff=0 on the next edge.
REQ-027 rst mid-run aborts the run without a done pulse; results read as reset values.
REQ-028 rst has priority over start in the same cycle.

Structure
REQ-029 Shared package holds the FSM state enumeration, the y_in bit-index constants (NOT_A..XNOR) and a function computing the expected 8-bit vector from (a,b).
REQ-030 One sub-module, gate_ref_model: combinational expected-vector generator from (a,b), reused by the bench as the golden model.

Verification
REQ-031 Correct gate block, SETTLE_CYCLES=2, start pulse -> done after 17 cycles, pass=1, err_count=0, fail_vec=4'b0000, first_diff=8'h00.
REQ-032 y_in bit6 (XOR) stuck at 0 -> vectors 1 and 2 fail: fail_vec=4'b0110, err_count=2, pass=0, first_diff has only bit6 set.
REQ-033 All y_in bits forced to 0 -> err_count=4, fail_vec=4'b1111, first_diff equal to the expected vector for a=0,b=0 (bits 0,1,2,5,7 set).
REQ-034 rst asserted during SETTLE of vector 2 -> no done pulse, all outputs at reset values next cycle; a new start then runs to pass=1.
REQ-035 start pulsed again while busy -> ignored; exactly one done pulse at the original 17-cycle latency.
REQ-036 SETTLE_CYCLES=1 and 15 -> latency 13 and 69 cycles respectively, a_out/b_out stable through each SETTLE window.

Source files
------------

// File: rtl/nand_gates_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_gates_checker_pkg
// Description : Shared types, y_in bit positions and the golden gate function
//               for the two-input gate block self-test checker.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_gates_checker_pkg;

    localparam int unsigned Y_W         = 8;
    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned CNT_W       = 4;

    // Bit positions of each gate output on y_in
    localparam int unsigned NOT_A = 0;
    localparam int unsigned NOT_B = 1;
    localparam int unsigned NAND  = 2;
    localparam int unsigned AND   = 3;
    localparam int unsigned OR    = 4;
    localparam int unsigned NOR   = 5;
    localparam int unsigned XOR   = 6;
    localparam int unsigned XNOR  = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [Y_W-1:0] expected_vector(input logic a, input logic b);
        logic [Y_W-1:0] v;
        v        = '0;
        v[NOT_A] = ~a;
        v[NOT_B] = ~b;
        v[NAND]  = ~(a & b);
        v[AND]   = a & b;
        v[OR]    = a | b;
        v[NOR]   = ~(a | b);
        v[XOR]   = a ^ b;
        v[XNOR]  = ~(a ^ b);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_gates_checker_gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational expected-vector generator for one (a,b) pair.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import nand_gates_checker_pkg::*;
(
    input  logic           a,
    input  logic           b,
    output logic [Y_W-1:0] y_exp
);

    assign y_exp = expected_vector(a, b);

endmodule
`default_nettype wire

// File: rtl/nand_gates_checker.sv
`default_nettype none
// ============================================================================
// Module      : nand_gates_checker
// Description : Walks all four (a,b) vectors through an external gate block,
//               compares its eight outputs and reports the run result.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_gates_checker
    import nand_gates_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [Y_W-1:0] y_in,
    output logic           a_out,
    output logic           b_out,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3:0]     fail_vec,
    output logic [2:0]     err_count,
    output logic [7:0]     first_diff
);

    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       c_last_index  = 2'(NUM_VECTORS - 1);

    state_t           r_state;
    logic [1:0]       r_index;
    logic [CNT_W-1:0] r_count;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_fail_vec;
    logic [2:0]       r_err_count;
    logic [Y_W-1:0]   r_first_diff;

    logic [Y_W-1:0]   w_y_exp;
    logic [Y_W-1:0]   w_diff;
    logic             w_mismatch;
    logic [2:0]       w_err_next;
    logic [1:0]       w_index_next;

    // Stimulus registers are the reference inputs, so the expected vector
    // always matches what the gate block is currently being driven with.
    gate_ref_model u_gate_ref_model (
        .a     (r_a),
        .b     (r_b),
        .y_exp (w_y_exp)
    );

    assign w_diff       = y_in ^ w_y_exp;
    assign w_mismatch   = |w_diff;
    assign w_err_next   = r_err_count + {2'b00, w_mismatch};
    assign w_index_next = r_index + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_count      <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_vec   <= '0;
            r_err_count  <= '0;
            r_first_diff <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_DRIVE;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_fail_vec   <= '0;
                        r_err_count  <= '0;
                        r_first_diff <= '0;
                        r_index      <= '0;
                        r_a          <= 1'b0;
                        r_b          <= 1'b0;
                    end
                end

                ST_DRIVE: begin
                    r_count <= c_settle_load;
                    r_state <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (r_count == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_vec[r_index] <= 1'b1;
                        r_err_count         <= w_err_next;
                        if (r_err_count == '0) begin
                            r_first_diff <= w_diff;
                        end
                    end
                    if (r_index == c_last_index) begin
                        // Pass uses the post-sample count so the last vector counts
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end else begin
                        r_index <= w_index_next;
                        r_a     <= w_index_next[1];
                        r_b     <= w_index_next[0];
                        r_state <= ST_DRIVE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_out      = r_a;
    assign b_out      = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_vec   = r_fail_vec;
    assign err_count  = r_err_count;
    assign first_diff = r_first_diff;

endmodule
`default_nettype wire

// File: tb/tb_nand_gates_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_gates_checker
// Description : Randomized self-checking bench for three checker instances
//               (SETTLE_CYCLES = 2, 1, 15) driven by a faulty-gate model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_gates_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] y_v      [3];
    logic [2:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [3:0] fail_v   [3];
    logic [2:0] err_v    [3];
    logic [7:0] diff_v   [3];

    logic       ref_a, ref_b;
    logic [7:0] ref_y;

    int checks;
    int errors;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nand_gates_checker #(
            .SETTLE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_v[g]),
            .y_in       (y_v[g]),
            .a_out      (a_v[g]),
            .b_out      (b_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .pass       (pass_v[g]),
            .fail_vec   (fail_v[g]),
            .err_count  (err_v[g]),
            .first_diff (diff_v[g])
        );
    end

    gate_ref_model u_gold (
        .a     (ref_a),
        .b     (ref_b),
        .y_exp (ref_y)
    );

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    // Truth-table arithmetic straight from the gate definitions
    function automatic logic [7:0] model_vec(input int a, input int b);
        int         bits [8];
        logic [7:0] v;
        bits[0] = 1 - a;
        bits[1] = 1 - b;
        bits[2] = 1 - a * b;
        bits[3] = a * b;
        bits[4] = (a + b > 0) ? 1 : 0;
        bits[5] = 1 - bits[4];
        bits[6] = (a + b) % 2;
        bits[7] = 1 - bits[6];
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = (bits[i] != 0);
        return v;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check_eq($sformatf("%s d%0d a_out", tag, d), 32'(a_v[d]), 0);
        check_eq($sformatf("%s d%0d b_out", tag, d), 32'(b_v[d]), 0);
        check_eq($sformatf("%s d%0d busy", tag, d), 32'(busy_v[d]), 0);
        check_eq($sformatf("%s d%0d done", tag, d), 32'(done_v[d]), 0);
        check_eq($sformatf("%s d%0d pass", tag, d), 32'(pass_v[d]), 0);
        check_eq($sformatf("%s d%0d fail_vec", tag, d), 32'(fail_v[d]), 0);
        check_eq($sformatf("%s d%0d err_count", tag, d), 32'(err_v[d]), 0);
        check_eq($sformatf("%s d%0d first_diff", tag, d), 32'(diff_v[d]), 0);
    endtask

    // One full run on instance d against gate outputs (good & and_m) | or_m.
    // extra_t > 0 pulses start again at that cycle after the accepted start.
    task automatic run_test(input int d, input logic [7:0] and_m, input logic [7:0] or_m,
                            input int extra_t, input string name);
        int         s, len, k, e_err;
        logic [7:0] f_vec [4];
        logic [7:0] g, dif, e_first;
        logic [3:0] e_fail;
        logic       e_pass;
        string      tg;
        s       = settle_of(d);
        len     = 4 * (s + 2) + 1;
        e_err   = 0;
        e_fail  = '0;
        e_first = '0;
        for (int v = 0; v < 4; v++) begin
            g        = model_vec(v / 2, v % 2);
            f_vec[v] = (g & and_m) | or_m;
            dif      = f_vec[v] ^ g;
            if (dif != 0) begin
                e_fail[v] = 1'b1;
                if (e_err == 0) e_first = dif;
                e_err++;
            end
        end
        e_pass = (e_err == 0);

        @(negedge clk);
        start_v[d] = 1'b1;
        y_v[d]     = 8'($urandom);
        for (int t = 1; t <= len + 2; t++) begin
            @(negedge clk);
            start_v[d] = (t == extra_t);
            tg = $sformatf("%s d%0d t%0d", name, d, t);
            k  = (t - 1) / (s + 2);
            if (k > 3) k = 3;
            if (t == 1) begin
                check_eq({tg, " cleared err_count"}, 32'(err_v[d]), 0);
                check_eq({tg, " cleared fail_vec"}, 32'(fail_v[d]), 0);
                check_eq({tg, " cleared pass"}, 32'(pass_v[d]), 0);
            end
            if (t < len) begin
                check_eq({tg, " a_out"}, 32'(a_v[d]), 32'(k / 2));
                check_eq({tg, " b_out"}, 32'(b_v[d]), 32'(k % 2));
                check_eq({tg, " busy"}, 32'(busy_v[d]), 1);
                check_eq({tg, " done"}, 32'(done_v[d]), 0);
            end else begin
                check_eq({tg, " done"}, 32'(done_v[d]), (t == len) ? 1 : 0);
                check_eq({tg, " busy"}, 32'(busy_v[d]), 0);
                check_eq({tg, " a_out"}, 32'(a_v[d]), 0);
                check_eq({tg, " b_out"}, 32'(b_v[d]), 0);
                check_eq({tg, " pass"}, 32'(pass_v[d]), 32'(e_pass));
                check_eq({tg, " fail_vec"}, 32'(fail_v[d]), 32'(e_fail));
                check_eq({tg, " err_count"}, 32'(err_v[d]), 32'(e_err));
                check_eq({tg, " first_diff"}, 32'(diff_v[d]), 32'(e_first));
            end
            // Only the SAMPLE cycle sees the gate value; everything else is noise
            if (t < len && t == (k + 1) * (s + 2)) y_v[d] = f_vec[k];
            else                                   y_v[d] = 8'($urandom);
        end
        start_v[d] = 1'b0;
    endtask

    task automatic reset_mid_run();
        int s, k, t_rst;
        s     = settle_of(0);
        t_rst = 1 + 2 * (s + 2) + 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        y_v[0]     = 8'($urandom);
        for (int t = 1; t <= t_rst; t++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            k = (t - 1) / (s + 2);
            check_eq($sformatf("rstrun t%0d a_out", t), 32'(a_v[0]), 32'(k / 2));
            check_eq($sformatf("rstrun t%0d busy", t), 32'(busy_v[0]), 1);
            y_v[0] = (t == (k + 1) * (s + 2)) ? 8'h00 : 8'($urandom);
        end
        check_eq("rstrun pre err_count", 32'(err_v[0]), 2);
        check_eq("rstrun pre fail_vec", 32'(fail_v[0]), 32'(4'b0011));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, "rstrun post");
        for (int t = t_rst + 2; t <= 4 * (s + 2) + 4; t++) begin
            @(negedge clk);
            check_eq($sformatf("rstrun t%0d no done", t), 32'(done_v[0]), 0);
            check_eq($sformatf("rstrun t%0d idle busy", t), 32'(busy_v[0]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] am, om;
        int         d;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start_v = '0;
        ref_a   = 1'b0;
        ref_b   = 1'b0;
        for (int i = 0; i < 3; i++) y_v[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_state(i, "reset");
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            ref_a = (v / 2 != 0);
            ref_b = (v % 2 != 0);
            #1;
            check_eq($sformatf("gold vec%0d", v), 32'(ref_y), 32'(model_vec(v / 2, v % 2)));
        end

        run_test(0, 8'hFF, 8'h00, 0, "clean");
        run_test(0, 8'hBF, 8'h00, 0, "xor_stuck0");
        check_eq("xor_stuck0 fail_vec", 32'(fail_v[0]), 32'(4'b0110));
        check_eq("xor_stuck0 err_count", 32'(err_v[0]), 2);
        check_eq("xor_stuck0 first_diff", 32'(diff_v[0]), 32'(8'h40));
        run_test(0, 8'h00, 8'h00, 0, "all_zero");
        check_eq("all_zero fail_vec", 32'(fail_v[0]), 32'(4'b1111));
        check_eq("all_zero err_count", 32'(err_v[0]), 4);
        check_eq("all_zero first_diff", 32'(diff_v[0]), 32'(8'hA7));
        run_test(0, 8'hFF, 8'h00, 7, "start_busy");
        run_test(0, 8'hFF, 8'h04, 17, "start_done");
        reset_mid_run();
        run_test(0, 8'hFF, 8'h00, 0, "after_rst");
        run_test(1, 8'hFF, 8'h00, 0, "settle1");
        run_test(2, 8'hFF, 8'h00, 0, "settle15");

        for (int i = 0; i < 10; i++) begin
            d = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0) begin
                am = 8'hFF;
                om = 8'h00;
            end else begin
                am = 8'($urandom | $urandom);
                om = 8'($urandom & $urandom & $urandom);
            end
            run_test(d, am, om, ($urandom_range(0, 1) == 1) ? 3 : 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
